// File: rtl/load_unit.sv
// load_unit: multi-cycle load path. It strobes MemRead for MEM_LATENCY cycles,
// captures MemData on the last of those cycles, and extracts a byte, halfword
// or word with zero or sign extension. Completion is signalled by a one-cycle
// done pulse. An illegal size select skips the memory access and pulses
// ld_error together with done.
module load_unit #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  LoadControl,
  input  logic        sign_ext,
  input  logic [31:0] MemData,
  output logic        MemRead,
  output logic        busy,
  output logic        done,
  output logic        ld_error,
  output logic [31:0] saida
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Counter value seen during the final READ cycle, i.e. on the capture edge.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [1:0]  lc_reg;
  logic        se_reg;
  logic [31:0] ext_value;

  // Extract and extend the returned word using only the request latched in IDLE.
  always_comb begin
    ext_value = MemData;
    case (lc_reg)
      2'd1:    ext_value = {{24{se_reg & MemData[7]}}, MemData[7:0]};
      2'd2:    ext_value = {{16{se_reg & MemData[15]}}, MemData[15:0]};
      default: ext_value = MemData;
    endcase
  end

  // Load sequencer. The outputs are registered alongside the state, so each
  // output already holds the value for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      lc_reg    <= 2'd0;
      se_reg    <= 1'b0;
      MemRead   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_error  <= 1'b0;
      saida     <= 32'h0000_0000;
    end else begin
      case (state_reg)
        IDLE: begin
          done     <= 1'b0;
          ld_error <= 1'b0;
          if (start) begin
            lc_reg <= LoadControl;
            se_reg <= sign_ext;
            busy   <= 1'b1;
            if (LoadControl == 2'd0) begin
              // An illegal size never touches memory and leaves saida alone.
              state_reg <= ERR;
              done      <= 1'b1;
              ld_error  <= 1'b1;
            end else begin
              state_reg <= READ;
              cnt_reg   <= 4'd0;
              MemRead   <= 1'b1;
            end
          end
        end
        READ: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            saida     <= ext_value;
            state_reg <= DONE;
            MemRead   <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        ERR: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          ld_error  <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          MemRead   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          ld_error  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed cases plus randomized loads. Expected
// results are pushed to a scoreboard at issue time; a monitor pops and
// compares them whenever done pulses.
module tb_load_unit;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  LoadControl = 2'd0;
  logic        sign_ext = 1'b0;
  logic [31:0] MemData = 32'h0;
  logic        MemRead;
  logic        busy;
  logic        done;
  logic        ld_error;
  logic [31:0] saida;

  typedef struct {
    logic [31:0] value;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_saida = 32'h0;
  int          checks = 0;
  int          errors = 0;

  load_unit #(.MEM_LATENCY(L)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .LoadControl(LoadControl),
    .sign_ext(sign_ext),
    .MemData(MemData),
    .MemRead(MemRead),
    .busy(busy),
    .done(done),
    .ld_error(ld_error),
    .saida(saida)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %h at %0t", name, act, $time);
    end
  endtask

  // Reference: the value a load should produce, from plain integer arithmetic.
  function automatic logic [31:0] ref_value(input logic [1:0] lc, input bit se,
                                            input logic [31:0] d, input logic [31:0] prev);
    longint v;
    case (lc)
      2'd0: return prev;
      2'd1: begin
        v = longint'(d) % 256;
        if (se && v >= 128) v = v - 256;
      end
      2'd2: begin
        v = longint'(d) % 65536;
        if (se && v >= 32768) v = v - 65536;
      end
      default: v = longint'(d);
    endcase
    return 32'(v);
  endfunction

  // Issue one request at the current negedge and walk it through to IDLE.
  // mode 0: quiet inputs; 1: random input noise while busy;
  // 2: LoadControl forced to 3, sign_ext flipped, start toggling while busy.
  task automatic do_load(input logic [1:0] lc, input bit se, input logic [31:0] data, input int mode);
    exp_t e;
    int   ncyc;
    start       = 1'b1;
    LoadControl = lc;
    sign_ext    = se;
    MemData     = $urandom;
    e.value     = ref_value(lc, se, data, model_saida);
    e.err       = (lc == 2'd0);
    model_saida = e.value;
    sb.push_back(e);
    ncyc = (lc == 2'd0) ? 2 : L + 2;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      check("memread", 32'(MemRead), 32'(lc != 2'd0 && k <= L));
      check("busy", 32'(busy), 32'(k < ncyc));
      check("done_timing", 32'(done), 32'(k == ncyc - 1));
      if (k == ncyc) begin
        start = 1'b0;
      end else begin
        case (mode)
          1: begin
            start       = 1'($urandom);
            LoadControl = 2'($urandom);
            sign_ext    = 1'($urandom);
          end
          2: begin
            start       = (k % 2) == 1;
            LoadControl = 2'd3;
            sign_ext    = ~se;
          end
          default: start = 1'b0;
        endcase
      end
      MemData = (k == L && lc != 2'd0) ? data : $urandom;
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (ld_error && !done) begin
      check("ld_error_without_done", 32'(ld_error), 32'(0));
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=1 exp=0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("saida", saida, e.value);
        check("ld_error", 32'(ld_error), 32'(e.err));
      end
    end
  end

  initial begin
    // Reset state.
    repeat (2) begin
      @(negedge clk);
      check("rst_memread", 32'(MemRead), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_ld_error", 32'(ld_error), 32'(0));
      check("rst_saida", saida, 32'h0);
    end
    reset = 1'b0;

    // Word load with cycle-exact timing.
    do_load(2'd3, 1'b0, 32'hDEADBEEF, 0);

    // Extension cases.
    do_load(2'd1, 1'b1, 32'h12348F80, 0);
    do_load(2'd1, 1'b0, 32'h12348F80, 0);
    do_load(2'd2, 1'b1, 32'h12348F80, 0);
    do_load(2'd2, 1'b0, 32'h12348F80, 0);
    do_load(2'd3, 1'b1, 32'h12348F80, 0);

    // Input stability: byte load while inputs change during READ.
    do_load(2'd1, 1'b0, 32'h12348F80, 2);

    // Illegal request keeps saida at 0x00000080.
    do_load(2'd0, 1'b0, 32'h0, 2);
    check("err_keeps_saida", saida, 32'h00000080);

    // Reset during the second READ cycle.
    start       = 1'b1;
    LoadControl = 2'd3;
    sign_ext    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_memread", 32'(MemRead), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_saida", saida, 32'h0);
    model_saida = 32'h0;
    @(negedge clk);
    check("midrst_done", 32'(done), 32'(0));
    reset = 1'b0;
    do_load(2'd3, 1'b0, 32'hCAFE1234, 0);

    // Randomized loads, back to back, with and without input noise.
    for (int i = 0; i < 150; i++) begin
      do_load(2'($urandom_range(0, 3)), 1'($urandom), $urandom, int'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle load-path unit for the processor datapath: the read-side counterpart of the store-merge logic. When the control unit requests a load, the block asserts the memory read strobe, waits a fixed memory latency, and captures the returned word. It then extracts the byte, halfword or full word, applies zero- or sign-extension, and presents the result for register write-back with a one-cycle completion pulse.

## Interface

Parameters:
- MEM_LATENCY, default 2: cycles from the first MemRead cycle until MemData is valid. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  load request, sampled only in IDLE.
- LoadControl  input  2  size select: 0 = illegal, 1 = byte (MemData[7:0]), 2 = halfword (MemData[15:0]), 3 = word.
- sign_ext  input  1  1 = sign-extend byte/halfword; 0 = zero-extend.
- MemData  input  32  memory read data.
- MemRead  output  1  memory read strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- ld_error  output  1  one-cycle pulse, coincident with done, for an illegal LoadControl.
- saida  output  32  extracted and extended load value; held between loads.

## Operation

States:
- IDLE: busy=0. On start=1, latch LoadControl and sign_ext.
  - If the latched LoadControl is 0, go to ERR.
  - Otherwise, load the counter with 0 and go to READ.
- READ: MemRead=1, busy=1. The counter increments each cycle.
  - On the edge that ends the MEM_LATENCY-th READ cycle, sample MemData, write the extracted value into saida, and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- ERR: done=1 and ld_error=1 for one cycle. saida is unchanged. Then go to IDLE.

Rules:
- start, LoadControl and sign_ext are ignored outside IDLE. A start asserted during DONE or ERR is dropped, not queued.
- Extraction uses only the latched LoadControl and sign_ext; input changes after acceptance have no effect.
- Byte extraction: saida = {24 copies of fill, MemData[7:0]}. fill = MemData[7] if sign_ext=1, else 0.
- Halfword extraction: saida = {16 copies of fill, MemData[15:0]}. fill = MemData[15] if sign_ext=1, else 0.
- Word extraction: saida = MemData. sign_ext has no effect.
- MemData is sampled only on the capture edge; all other values are don't-care.
- The counter is 4 bits wide and never wraps, because MEM_LATENCY is at most 15.

Reset:
- Asynchronous; takes effect immediately, including in the middle of a load.
- The state goes to IDLE and the counter to 0.
- MemRead, busy, done and ld_error all go to 0. saida goes to 0x00000000.
- A load in progress is abandoned and produces no done pulse.

## Timing

- Cycle 0: start is sampled high in IDLE.
- Cycles 1..MEM_LATENCY: READ, with MemRead=1.
- Cycle MEM_LATENCY+1: DONE, with done=1 and the new saida valid.
- Cycle MEM_LATENCY+2: IDLE. The earliest next start is accepted at the end of this cycle.
- Load issue-to-issue period: MEM_LATENCY+2 cycles.
- Illegal request: ERR in cycle 1, IDLE in cycle 2.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.
- saida changes only on a capture edge or on reset.

## Test plan

- Reset state: assert reset for 2 cycles, with no start -> MemRead, busy, done and ld_error all 0; saida = 0x00000000.
- Word load (MEM_LATENCY=2, LoadControl=3, MemData=0xDEADBEEF):
  - MemRead high exactly in cycles 1-2.
  - done pulses in cycle 3, with saida = 0xDEADBEEF.
  - busy falls in cycle 4.
- Byte and halfword extension (MemData=0x12348F80):
  - byte, sign_ext=1 -> 0xFFFFFF80.
  - byte, sign_ext=0 -> 0x00000080.
  - halfword, sign_ext=1 -> 0xFFFF8F80.
  - halfword, sign_ext=0 -> 0x00008F80.
  - word, sign_ext=1 -> 0x12348F80.
- Input stability: change LoadControl from 1 to 3 and toggle start during READ -> the result still uses byte extraction. No second load starts; busy drops after a single done.
- Illegal request: LoadControl=0 with start -> ld_error and done both pulse in cycle 1. MemRead never asserts. saida keeps its previous value (e.g. 0x00000080).
- Reset mid-load: assert reset during the second READ cycle -> MemRead and busy drop immediately with no done pulse. A new start after reset deasserts completes normally, with saida = the new data.
